mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide RAM/IO bus between three requesters: ROB commit (stores, IO reads), LSB loads, fetcher.
//  Serialises each 1/2/4-byte access into per-byte bus cycles and assembles read data little-endian.
//  Aborts speculative reads on misprediction flush.
// PARAMETERS
//  IO_SEL_HI  17  high bit of IO decode; addr[IO_SEL_HI:IO_SEL_HI-1]==2'b11 marks an IO address
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   reset; asynchronous, active-low
//  rdy            in   1   global ready; low freezes all state
//  flush          in   1   misprediction flush (ROB out_xbp)
//  if_req         in   1   fetch request, level; held until if_done
//  if_addr        in   32  fetch address; size always 4
//  if_done        out  1   one-cycle pulse, if_data valid
//  if_data        out  32  instruction word
//  lsb_req        in   1   load request, level
//  lsb_addr       in   32  load address
//  lsb_size       in   3   1, 2 or 4 bytes
//  lsb_done       out  1   one-cycle pulse
//  lsb_data       out  32  zero-extended load data
//  rob_req        in   1   commit access request, level
//  rob_wr         in   1   1 = store, 0 = IO read
//  rob_addr       in   32  address
//  rob_size       in   3   1, 2 or 4 bytes
//  rob_wdata      in   32  store data, low bytes used
//  rob_done       out  1   one-cycle pulse
//  rob_rdata      out  32  IO read data, zero-extended
//  mem_din        in   8   RAM read byte
//  mem_dout       out  8   RAM write byte
//  mem_a          out  32  RAM byte address
//  mem_wr         out  1   1 = write
//  io_buffer_full in   1   IO write buffer full
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; mem_a, mem_dout, all *_data and rob_rdata = 0; mem_wr and all *_done = 0.
//   Reset mid-transaction drops the transaction immediately; no done pulse is issued.
//  States: IDLE, READ, WRITE; byte counter cnt (0..size).
//  IDLE: choose a requester, latch addr/size/wdata/grant ID, drive mem_a <= addr, cnt <= 0.
//   Next state is WRITE for rob_wr=1, else READ.
//  Priority: rob > lsb > if (fixed).
//  READ: RAM latency is one cycle.
//   Grant at edge 0 puts byte k on mem_a after edge k; mem_din is sampled at edge k+2.
//   Final byte is merged straight from mem_din; done and data are registered at edge N+1 (N = size).
//   Back to IDLE.
//  WRITE: byte k is driven with mem_wr=1 in the cycle after edge k; done at edge N, then IDLE.
//   IO address with io_buffer_full=1: mem_wr is held 0 and cnt does not advance until io_buffer_full=0.
//  Exactly one done pulse per grant, one cycle wide. At least one IDLE cycle between transactions.
//  flush=1: a READ granted to if or lsb returns to IDLE at the next edge with no done pulse.
//   Pending if/lsb requests are ignored that cycle; rob transactions are never aborted.
//   flush in IDLE blocks if/lsb grant only.
//  rdy=0: no register updates; mem_wr is forced to 0 combinationally.
//  Addresses use 32-bit wrap (addr+cnt); unaligned accesses are permitted.
//  Dropping req before done is illegal except when flush=1.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: lsb and if are granted round-robin; the one last granted loses the tie. rob stays highest.
//  MEM_ARB_RR_EN undefined: fixed priority as above.
// STRUCTURE
//  definition.v gets `MEM_IDLE / `MEM_READ / `MEM_WRITE encodings, `REQ_ROB / `REQ_LSB / `REQ_IF IDs and the IO decode macro.
//  Sub-module mem_arb_pick: combinational grant selection including the RR pointer input.
//  Byte assembly and counters live in the top module.
// TESTING
//  1. if_req, addr 0x100, RAM 0x13,0x05,0x00,0x00 -> if_done after edge 5; if_data = 0x00000513.
//  2. rob_req, wr=1, size 4, addr 0x200, wdata 0xDEADBEEF -> bytes EF,BE,AD,DE to 0x200..0x203; rob_done after edge 4.
//  3. rob, lsb and if requests in the same cycle -> grant order rob, lsb, if.
//     With MEM_ARB_RR_EN, repeated lsb/if contention alternates grants.
//  4. lsb_req size 2 at 0x300 (RAM 0x80,0xFF), flush at edge 2 -> no lsb_done; IDLE next cycle; store still completes.
//  5. rob store size 1 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr stays 0 for those cycles, then one write.
//     rob_done follows one cycle later.
//  6. rst_n low mid-READ -> outputs return to reset values at once; no done pulse; a new request after release is served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: FSM states, requester IDs, IO decode default
// and the little-endian byte merge helper.
package mem_arbiter_pkg;

   localparam int IO_SEL_HI_DEF = 17;

   typedef enum logic [1:0] {
      MEM_IDLE,
      MEM_READ,
      MEM_WRITE
   } state_t;

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_ROB,
      REQ_LSB,
      REQ_IF
   } req_id_t;

   function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
      logic [31:0] r;
      r = word;
      r[{idx, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for mem_arbiter: rob always first, then lsb/if.
// With MEM_ARB_RR_EN defined an lsb/if tie goes to whichever was not granted last.
module mem_arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic    rob_req_i,
   input  logic    lsb_req_i,
   input  logic    if_req_i,
   input  logic    last_lsb_i,
   output req_id_t gnt_o
);

   logic lsb_wins;

`ifdef MEM_ARB_RR_EN
   assign lsb_wins = !last_lsb_i;
`else
   logic unused_last_lsb;
   assign lsb_wins        = 1'b1;
   assign unused_last_lsb = last_lsb_i;
`endif

   always_comb begin
      gnt_o = REQ_NONE;
      if (rob_req_i) begin
         gnt_o = REQ_ROB;
      end else if (lsb_req_i && (!if_req_i || lsb_wins)) begin
         gnt_o = REQ_LSB;
      end else if (if_req_i) begin
         gnt_o = REQ_IF;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO bus arbiter for rob commit, lsb loads and instruction fetch.
// Optional MEM_ARB_RR_EN enables round-robin between lsb and if (see mem_arb_pick).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int IO_SEL_HI = IO_SEL_HI_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        lsb_req,
   input  logic [31:0] lsb_addr,
   input  logic [2:0]  lsb_size,
   output logic        lsb_done,
   output logic [31:0] lsb_data,
   input  logic        rob_req,
   input  logic        rob_wr,
   input  logic [31:0] rob_addr,
   input  logic [2:0]  rob_size,
   input  logic [31:0] rob_wdata,
   output logic        rob_done,
   output logic [31:0] rob_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   state_t      state_q, state_d;
   req_id_t     gnt_q, gnt_d, pick_gnt;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
   logic [2:0]  size_q, size_d, cnt_q, cnt_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [7:0]  mem_dout_q, mem_dout_d;
   logic        if_done_q, if_done_d, lsb_done_q, lsb_done_d, rob_done_q, rob_done_d;
   logic [31:0] if_data_q, if_data_d, lsb_data_q, lsb_data_d, rob_rdata_q, rob_rdata_d;
   logic        rr_last_lsb_q, rr_last_lsb_d;
   logic        io_stall;
   logic [31:0] merged;
   logic [1:0]  nidx;

   mem_arb_pick u_pick (
      .rob_req_i  (rob_req),
      .lsb_req_i  (lsb_req && !flush),
      .if_req_i   (if_req && !flush),
      .last_lsb_i (rr_last_lsb_q),
      .gnt_o      (pick_gnt)
   );

   assign io_stall = (mem_a_q[IO_SEL_HI -: 2] == 2'b11) && io_buffer_full;
   // Byte cnt-1 arrives on mem_din now; the last byte is merged without a buffer stage.
   assign merged   = merge_byte(buf_q, 2'(cnt_q - 3'd1), mem_din);
   assign nidx     = cnt_q[1:0] + 2'd1;

   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      addr_d        = addr_q;
      size_d        = size_q;
      wdata_d       = wdata_q;
      cnt_d         = cnt_q;
      buf_d         = buf_q;
      mem_a_d       = mem_a_q;
      mem_dout_d    = mem_dout_q;
      if_done_d     = 1'b0;
      lsb_done_d    = 1'b0;
      rob_done_d    = 1'b0;
      if_data_d     = if_data_q;
      lsb_data_d    = lsb_data_q;
      rob_rdata_d   = rob_rdata_q;
      rr_last_lsb_d = rr_last_lsb_q;
      case (state_q)
         MEM_IDLE: begin
            if (pick_gnt != REQ_NONE) begin
               gnt_d   = pick_gnt;
               cnt_d   = 3'd0;
               buf_d   = 32'd0;
               state_d = MEM_READ;
               case (pick_gnt)
                  REQ_ROB: begin
                     addr_d  = rob_addr;
                     size_d  = rob_size;
                     wdata_d = rob_wdata;
                     if (rob_wr) state_d = MEM_WRITE;
                  end
                  REQ_LSB: begin
                     addr_d        = lsb_addr;
                     size_d        = lsb_size;
                     rr_last_lsb_d = 1'b1;
                  end
                  default: begin
                     addr_d        = if_addr;
                     size_d        = 3'd4;
                     rr_last_lsb_d = 1'b0;
                  end
               endcase
               mem_a_d    = addr_d;
               mem_dout_d = wdata_d[7:0];
            end
         end
         MEM_READ: begin
            if (flush && gnt_q != REQ_ROB) begin
               state_d = MEM_IDLE;
            end else if (cnt_q == size_q) begin
               state_d = MEM_IDLE;
               case (gnt_q)
                  REQ_ROB: begin rob_done_d = 1'b1; rob_rdata_d = merged; end
                  REQ_LSB: begin lsb_done_d = 1'b1; lsb_data_d  = merged; end
                  REQ_IF:  begin if_done_d  = 1'b1; if_data_d   = merged; end
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q != 3'd0) buf_d = merged;
               if ((cnt_q + 3'd1) < size_q) mem_a_d = addr_q + 32'(cnt_q) + 32'd1;
            end
         end
         MEM_WRITE: begin
            if (!io_stall) begin
               if ((cnt_q + 3'd1) == size_q) begin
                  state_d    = MEM_IDLE;
                  cnt_d      = size_q;
                  rob_done_d = 1'b1;
               end else begin
                  cnt_d      = cnt_q + 3'd1;
                  mem_a_d    = addr_q + 32'(cnt_q) + 32'd1;
                  mem_dout_d = wdata_q[{nidx, 3'b000} +: 8];
               end
            end
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= MEM_IDLE;
         gnt_q         <= REQ_NONE;
         addr_q        <= 32'd0;
         size_q        <= 3'd0;
         wdata_q       <= 32'd0;
         cnt_q         <= 3'd0;
         buf_q         <= 32'd0;
         mem_a_q       <= 32'd0;
         mem_dout_q    <= 8'd0;
         if_done_q     <= 1'b0;
         lsb_done_q    <= 1'b0;
         rob_done_q    <= 1'b0;
         if_data_q     <= 32'd0;
         lsb_data_q    <= 32'd0;
         rob_rdata_q   <= 32'd0;
         rr_last_lsb_q <= 1'b0;
      end else if (rdy) begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         addr_q        <= addr_d;
         size_q        <= size_d;
         wdata_q       <= wdata_d;
         cnt_q         <= cnt_d;
         buf_q         <= buf_d;
         mem_a_q       <= mem_a_d;
         mem_dout_q    <= mem_dout_d;
         if_done_q     <= if_done_d;
         lsb_done_q    <= lsb_done_d;
         rob_done_q    <= rob_done_d;
         if_data_q     <= if_data_d;
         lsb_data_q    <= lsb_data_d;
         rob_rdata_q   <= rob_rdata_d;
         rr_last_lsb_q <= rr_last_lsb_d;
      end
   end

   assign mem_wr    = rdy && (state_q == MEM_WRITE) && !io_stall;
   assign mem_a     = mem_a_q;
   assign mem_dout  = mem_dout_q;
   assign if_done   = if_done_q;
   assign if_data   = if_data_q;
   assign lsb_done  = lsb_done_q;
   assign lsb_data  = lsb_data_q;
   assign rob_done  = rob_done_q;
   assign rob_rdata = rob_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then randomized traffic
// against a byte-level memory reference; a negedge monitor pops expectations.
module tb_mem_arbiter;

   logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, flush = 1'b0;
   logic        if_req = 1'b0, lsb_req = 1'b0, rob_req = 1'b0, rob_wr = 1'b0;
   logic [31:0] if_addr = '0, lsb_addr = '0, rob_addr = '0, rob_wdata = '0;
   logic [2:0]  lsb_size = 3'd1, rob_size = 3'd1;
   logic        io_buffer_full = 1'b0;
   logic [7:0]  mem_din = '0;
   logic        if_done, lsb_done, rob_done, mem_wr;
   logic [31:0] if_data, lsb_data, rob_rdata, mem_a;
   logic [7:0]  mem_dout;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
      .lsb_done(lsb_done), .lsb_data(lsb_data),
      .rob_req(rob_req), .rob_wr(rob_wr), .rob_addr(rob_addr), .rob_size(rob_size),
      .rob_wdata(rob_wdata), .rob_done(rob_done), .rob_rdata(rob_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int n_lsb_done = 0;
   logic [31:0] if_q[$], lsb_q[$], wa_q[$];
   logic [32:0] rob_q[$];
   logic [7:0]  wd_q[$];
   logic [7:0]  dev_mem [logic [31:0]];

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   // RAM contents: a few fixed bytes from the directed cases, a hash elsewhere.
   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      case (a)
         32'h100: return 8'h13;
         32'h101: return 8'h05;
         32'h102: return 8'h00;
         32'h103: return 8'h00;
         32'h300: return 8'h80;
         32'h301: return 8'hFF;
         default: return 8'((a * 32'd7) ^ (a >> 9));
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a, input int size);
      logic [31:0] r = 32'd0;
      for (int k = 0; k < size; k++) r = r | (32'(ref_byte(a + 32'(k))) << (8 * k));
      return r;
   endfunction

   // Bus-side RAM with one cycle read latency.
   always @(posedge clk) begin
      if (mem_wr) dev_mem[mem_a] = mem_dout;
      mem_din <= dev_mem.exists(mem_a) ? dev_mem[mem_a] : ref_byte(mem_a);
   end

   always @(negedge clk) begin
      logic [31:0] e;
      logic [32:0] r;
      if (rst_n) begin
         if (if_done) begin
            check_eq("if_done_expected", 32'(if_q.size() > 0), 32'd1);
            if (if_q.size() > 0) begin e = if_q.pop_front(); check_eq("if_data", if_data, e); end
         end
         if (lsb_done) begin
            n_lsb_done++;
            check_eq("lsb_done_expected", 32'(lsb_q.size() > 0), 32'd1);
            if (lsb_q.size() > 0) begin e = lsb_q.pop_front(); check_eq("lsb_data", lsb_data, e); end
         end
         if (rob_done) begin
            check_eq("rob_done_expected", 32'(rob_q.size() > 0), 32'd1);
            if (rob_q.size() > 0) begin
               r = rob_q.pop_front();
               if (r[32]) check_eq("rob_rdata", rob_rdata, r[31:0]);
            end
         end
         if (mem_wr) begin
            check_eq("write_expected", 32'(wa_q.size() > 0), 32'd1);
            if (wa_q.size() > 0) begin
               check_eq("write_addr", mem_a, wa_q.pop_front());
               check_eq("write_data", 32'(mem_dout), 32'(wd_q.pop_front()));
            end
         end
      end
   end

   task automatic issue_if(input logic [31:0] a);
      if_q.push_back(ref_read(a, 4));
      if_addr = a; if_req = 1'b1;
   endtask

   task automatic issue_lsb(input logic [31:0] a, input int s);
      lsb_q.push_back(ref_read(a, s));
      lsb_addr = a; lsb_size = 3'(s); lsb_req = 1'b1;
   endtask

   task automatic issue_rob_wr(input logic [31:0] a, input int s, input logic [31:0] d);
      for (int k = 0; k < s; k++) begin
         wa_q.push_back(a + 32'(k));
         wd_q.push_back(8'(d >> (8 * k)));
      end
      rob_q.push_back({1'b0, 32'd0});
      rob_addr = a; rob_size = 3'(s); rob_wdata = d; rob_wr = 1'b1; rob_req = 1'b1;
   endtask

   task automatic issue_rob_rd(input logic [31:0] a, input int s);
      rob_q.push_back({1'b1, ref_read(a, s)});
      rob_addr = a; rob_size = 3'(s); rob_wr = 1'b0; rob_req = 1'b1;
   endtask

   // Counts clock edges until the chosen done (0 rob, 1 lsb, 2 if) is seen.
   task automatic wait_done(input int which, input string name, output int edges);
      bit seen = 1'b0;
      edges = 0;
      while (!seen && edges < 40) begin
         @(posedge clk); #1;
         edges++;
         case (which)
            0: seen = rob_done;
            1: seen = lsb_done;
            default: seen = if_done;
         endcase
      end
      check_eq({name, "_seen"}, 32'(seen), 32'd1);
   endtask

   function automatic int pick_size();
      int r = int'($urandom_range(0, 2));
      return (r == 0) ? 1 : (r == 1) ? 2 : 4;
   endfunction

   initial begin
      int e;
      int order[$];
      int exp_order[4];
      bit lsb_again;
      bit busy_if = 0, busy_lsb = 0, busy_rob = 0;
      int snap;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_mem_a", mem_a, 32'd0);
      check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
      check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
      check_eq("rst_dones", {29'd0, if_done, lsb_done, rob_done}, 32'd0);
      check_eq("rst_data", if_data | lsb_data | rob_rdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue_if(32'h100);
      wait_done(2, "t1_if", e);
      check_eq("t1_if_latency", 32'(e), 32'd6);
      if_req = 1'b0;

      issue_rob_wr(32'h200, 4, 32'hDEADBEEF);
      wait_done(0, "t2_store", e);
      check_eq("t2_store_latency", 32'(e), 32'd5);
      rob_req = 1'b0;
      @(posedge clk); #1;

      issue_rob_rd(32'h30104, 1);
      issue_lsb(32'h400, 1);
      issue_if(32'h500);
      lsb_again = 1'b0;
      for (int c = 0; c < 80 && order.size() < 4; c++) begin
         @(posedge clk); #1;
         if (rob_done) begin order.push_back(0); rob_req = 1'b0; end
         if (lsb_done) begin
            order.push_back(1);
            if (!lsb_again) begin lsb_again = 1'b1; issue_lsb(32'h404, 2); end
            else lsb_req = 1'b0;
         end
         if (if_done) begin order.push_back(2); if_req = 1'b0; end
      end
`ifdef MEM_ARB_RR_EN
      exp_order = '{0, 1, 2, 1};
`else
      exp_order = '{0, 1, 1, 2};
`endif
      check_eq("t3_grant_count", 32'(order.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < order.size()) check_eq($sformatf("t3_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
      lsb_req = 1'b0; if_req = 1'b0; rob_req = 1'b0;
      @(posedge clk); #1;

      snap = n_lsb_done;
      issue_lsb(32'h300, 2);
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1;
      void'(lsb_q.pop_back());
      lsb_req = 1'b0;
      issue_rob_wr(32'h1020, 1, 32'h5C);
      @(posedge clk); #1;
      flush = 1'b0;
      wait_done(0, "t4_store", e);
      check_eq("t4_idle_then_store", 32'(e), 32'd2);
      rob_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("t4_no_lsb_done", 32'(n_lsb_done), 32'(snap));

      issue_rob_wr(32'h30000, 1, 32'h77);
      io_buffer_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_eq("t5_io_stall_wr", 32'(mem_wr), 32'd0);
      end
      @(posedge clk); #1;
      io_buffer_full = 1'b0;
      #1;
      check_eq("t5_io_write", 32'(mem_wr), 32'd1);
      wait_done(0, "t5_store", e);
      check_eq("t5_done_latency", 32'(e), 32'd1);
      rob_req = 1'b0;
      @(posedge clk); #1;

      issue_if(32'h104);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_eq("t6_mem_a", mem_a, 32'd0);
      check_eq("t6_if_data", if_data, 32'd0);
      check_eq("t6_lsb_data", lsb_data, 32'd0);
      check_eq("t6_rob_rdata", rob_rdata, 32'd0);
      check_eq("t6_dones", {29'd0, if_done, lsb_done, rob_done}, 32'd0);
      void'(if_q.pop_back());
      if_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue_if(32'h100);
      wait_done(2, "t6_after_reset", e);
      check_eq("t6_if_latency", 32'(e), 32'd6);
      if_req = 1'b0;

      issue_rob_wr(32'h1010, 2, 32'h0000A5C3);
      @(posedge clk); #1;
      rdy = 1'b0;
      #1;
      check_eq("t7_rdy_low_wr", 32'(mem_wr), 32'd0);
      @(posedge clk); #1;
      check_eq("t7_rdy_low_wr2", 32'(mem_wr), 32'd0);
      @(posedge clk); #1;
      rdy = 1'b1;
      #1;
      check_eq("t7_rdy_high_wr", 32'(mem_wr), 32'd1);
      wait_done(0, "t7_store", e);
      check_eq("t7_done_latency", 32'(e), 32'd2);
      rob_req = 1'b0;
      @(posedge clk); #1;

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (rob_done) begin busy_rob = 0; rob_req = 1'b0; end
         if (lsb_done) begin busy_lsb = 0; lsb_req = 1'b0; end
         if (if_done)  begin busy_if = 0;  if_req = 1'b0; end
         io_buffer_full = ($urandom_range(0, 2) == 0);
         flush = ($urandom_range(0, 39) == 0);
         if (flush) begin
            if (busy_lsb) begin void'(lsb_q.pop_back()); busy_lsb = 0; lsb_req = 1'b0; end
            if (busy_if)  begin void'(if_q.pop_back());  busy_if = 0;  if_req = 1'b0; end
         end
         if (!busy_rob && $urandom_range(0, 3) == 0) begin
            busy_rob = 1;
            if ($urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 3) == 0) issue_rob_wr(32'h30000 + $urandom_range(0, 12), 1 + int'($urandom_range(0, 1)), $urandom);
               else issue_rob_wr(32'h1000 + $urandom_range(0, 255), pick_size(), $urandom);
            end else begin
               issue_rob_rd(32'h30100 + $urandom_range(0, 60), pick_size());
            end
         end
         if (!flush && !busy_lsb && $urandom_range(0, 2) == 0) begin
            busy_lsb = 1;
            if ($urandom_range(0, 15) == 0) issue_lsb(32'hFFFF_FFFC + $urandom_range(0, 3), pick_size());
            else issue_lsb(32'h2000 + $urandom_range(0, 255), pick_size());
         end
         if (!flush && !busy_if && $urandom_range(0, 2) == 0) begin
            busy_if = 1;
            if ($urandom_range(0, 15) == 0) issue_if(32'hFFFF_FFFE);
            else issue_if(32'h2000 + $urandom_range(0, 255));
         end
      end

      flush = 1'b0;
      io_buffer_full = 1'b0;
      for (int c = 0; c < 300 && (busy_rob || busy_lsb || busy_if); c++) begin
         @(posedge clk); #1;
         if (rob_done) begin busy_rob = 0; rob_req = 1'b0; end
         if (lsb_done) begin busy_lsb = 0; lsb_req = 1'b0; end
         if (if_done)  begin busy_if = 0;  if_req = 1'b0; end
      end
      @(negedge clk); #1;
      check_eq("drain_if", 32'(if_q.size()), 32'd0);
      check_eq("drain_lsb", 32'(lsb_q.size()), 32'd0);
      check_eq("drain_rob", 32'(rob_q.size()), 32'd0);
      check_eq("drain_writes", 32'(wa_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

endmodule
